// File: rtl/imem_loader.sv
// Program loader: takes a count/data/checksum byte stream, writes 32-bit words
// into instruction memory from address 0 and releases the core once the checksum matches.
module imem_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic              im_mode,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_din,
   output logic              core_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        dbg_state
);

   localparam int CW = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_n;
   logic [CW-1:0]     r_idx;
   logic [1:0]        r_bcnt;
   logic [7:0]        r_xor;
   logic [31:0]       r_word;
   logic              r_in_ready;
   logic              r_im_we;
   logic              r_im_mode;
   logic [ADDR_W-1:0] r_im_addr;
   logic [31:0]       r_im_din;
   logic              r_core_en;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   state_t            w_nxt;
   logic              w_acc;
   logic              w_cnt_bad;
   logic [CW-1:0]     w_idx_inc;
   logic [31:0]       w_word_nxt;

   // Valid/ready: a byte moves on a rising edge where in_valid and in_ready are both 1;
   // in_ready is a register, so it never depends combinationally on in_valid.
   always_comb begin
      w_nxt      = r_state;
      w_acc      = in_valid & r_in_ready;
      w_cnt_bad  = (in_data == 8'd0) || ({24'd0, in_data} > DEPTH);
      w_idx_inc  = r_idx + CW'(1);
      w_word_nxt = {r_word[23:0], in_data};
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (start) w_nxt = S_COUNT;
         S_COUNT: if (w_acc) w_nxt = w_cnt_bad ? S_ERR : S_DATA;
         S_DATA:  if (w_acc && (r_bcnt == 2'd3)) w_nxt = S_WRITE;
         S_WRITE: w_nxt = (w_idx_inc == r_n) ? S_CHECK : S_DATA;
         S_CHECK: if (w_acc) w_nxt = (in_data == r_xor) ? S_DONE : S_ERR;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_n        <= '0;
         r_idx      <= '0;
         r_bcnt     <= '0;
         r_xor      <= '0;
         r_word     <= '0;
         r_in_ready <= 1'b0;
         r_im_we    <= 1'b0;
         r_im_mode  <= 1'b1;
         r_im_addr  <= '0;
         r_im_din   <= '0;
         r_core_en  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_nxt;
         case (r_state)
            S_COUNT: begin
               if (w_acc && !w_cnt_bad) begin
                  r_n    <= CW'(in_data);
                  r_idx  <= '0;
                  r_bcnt <= '0;
                  r_xor  <= in_data;
               end
            end
            S_DATA: begin
               if (w_acc) begin
                  r_word <= w_word_nxt;
                  r_xor  <= r_xor ^ in_data;
                  r_bcnt <= r_bcnt + 2'd1;
               end
            end
            S_WRITE: r_idx <= w_idx_inc;
            default: ;
         endcase

         // Outputs are registered from the next state so they line up with r_state.
         r_in_ready <= (w_nxt == S_COUNT) || (w_nxt == S_DATA) || (w_nxt == S_CHECK);
         r_busy     <= (w_nxt == S_COUNT) || (w_nxt == S_DATA) ||
                       (w_nxt == S_WRITE) || (w_nxt == S_CHECK);
         r_done     <= (w_nxt == S_DONE);
         r_core_en  <= (w_nxt == S_DONE);
         r_err      <= (w_nxt == S_ERR);
         r_im_we    <= (w_nxt == S_WRITE);
         r_im_mode  <= (w_nxt != S_WRITE);
         r_im_addr  <= (w_nxt == S_WRITE) ? r_idx[ADDR_W-1:0] : '0;
         r_im_din   <= (w_nxt == S_WRITE) ? w_word_nxt : '0;
      end
   end

   assign in_ready  = r_in_ready;
   assign im_we     = r_im_we;
   assign im_mode   = r_im_mode;
   assign im_addr   = r_im_addr;
   assign im_din    = r_im_din;
   assign core_en   = r_core_en;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad count, bad checksum, stalls,
// mid-load reset, ignored start and a full 32-word reload.
module tb_imem_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              im_we;
  logic              im_mode;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_din;
  logic              core_en;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_mode(im_mode), .im_addr(im_addr),
    .im_din(im_din), .core_en(core_en), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   tx_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // write monitor: captures every memory write and checks idle output values
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_q.push_back({im_addr, im_din});
      check("we_ctl", 64'({in_ready, im_mode}), 64'(2'b00));
    end else begin
      check("idle_out", 64'({im_mode, im_addr, im_din}), 64'({1'b1, {W{1'b0}}}));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // driver tasks
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_stream(input bit stall, input int start_at);
    int  i = 0;
    int  budget = 0;
    bit  xfer;
    while (i < tx_q.size()) begin
      if (budget > 4000) begin
        check("stream_timeout", 64'(i), 64'(tx_q.size()));
        break;
      end
      in_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = in_valid ? tx_q[i] : 8'($urandom_range(0, 255));
      start    = (i == start_at);
      xfer     = in_valid && in_ready;
      @(negedge clk);
      budget++;
      if (xfer) i++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic load_nominal(input logic [7:0] csum);
    tx_q = '{8'h02, 8'h20, 8'h09, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08, csum};
    exp_q.push_back({5'd0, 32'h2009_0005});
    exp_q.push_back({5'd1, 32'h0000_0008});
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_q.size() > 0)
      check({tag, "_wr"}, 64'(wr_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, 64'({in_ready, im_we, core_en, busy, done, err}), 64'(0));
    check({tag, "_mem"}, 64'({im_mode, im_addr, im_din}), 64'({1'b1, {W{1'b0}}}));
    check({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  initial begin
    logic [7:0]  csum;
    logic [31:0] word;

    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    reset = 1'b1;
    @(negedge clk);

    // nominal load
    load_nominal(8'h26);
    do_start();
    check("nom_busy", 64'({busy, in_ready, done}), 64'(3'b110));
    send_stream(1'b0, -1);
    check("nom_cycles", 64'(cyc - t0), 64'(12));
    check("nom_status", 64'({done, core_en, err, busy}), 64'(4'b1100));
    check_writes("nom");
    repeat (3) @(negedge clk);
    check("nom_sticky", 64'({done, core_en, err, busy}), 64'(4'b1100));

    // start in DONE drops core_en; start pulsed during DATA is ignored
    load_nominal(8'h26);
    do_start();
    check("restart_drop", 64'({done, core_en, busy}), 64'(3'b001));
    send_stream(1'b0, 3);
    check("ign_cycles", 64'(cyc - t0), 64'(12));
    check("ign_status", 64'({done, core_en, err, busy}), 64'(4'b1100));
    check_writes("ign");

    // bad checksum
    load_nominal(8'h27);
    do_start();
    send_stream(1'b0, -1);
    check("bcs_status", 64'({done, core_en, err, busy}), 64'(4'b0010));
    check_writes("bcs");

    // bad count 0x00 then 0x21
    do_start();
    check("err_clear", 64'({err, busy}), 64'(2'b01));
    tx_q = '{8'h00};
    send_stream(1'b0, -1);
    check("cnt0_cycles", 64'(cyc - t0), 64'(1));
    check("cnt0_status", 64'({done, core_en, err, busy}), 64'(4'b0010));
    check_writes("cnt0");
    do_start();
    tx_q = '{8'h21};
    send_stream(1'b0, -1);
    check("cnt33_cycles", 64'(cyc - t0), 64'(1));
    check("cnt33_status", 64'({done, core_en, err, busy}), 64'(4'b0010));
    repeat (3) @(negedge clk);
    check_writes("cnt33");

    // stalled stream
    load_nominal(8'h26);
    do_start();
    send_stream(1'b1, -1);
    check("stall_status", 64'({done, core_en, err, busy}), 64'(4'b1100));
    check_writes("stall");

    // reset after the 6th byte: only word 0 is ever written
    load_nominal(8'h26);
    tx_q = tx_q[0:5];
    void'(exp_q.pop_back());
    do_start();
    send_stream(1'b0, -1);
    check("mid_busy", 64'({busy, dbg_state}), 64'({1'b1, 3'd2}));
    reset = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    repeat (4) @(negedge clk);
    check_reset_outs("mid_hold");
    reset = 1'b1;
    @(negedge clk);
    check_writes("mid");

    load_nominal(8'h26);
    do_start();
    send_stream(1'b0, -1);
    check("post_rst_status", 64'({done, core_en, err, busy}), 64'(4'b1100));
    check_writes("post_rst");

    // full 32-word load from DONE
    tx_q.delete();
    tx_q.push_back(8'h20);
    csum = 8'h20;
    for (int i = 0; i < DEPTH; i++) begin
      word = {8'(i), 8'(i * 7), 8'hC3, ~8'(i)};
      for (int b = 3; b >= 0; b--) begin
        tx_q.push_back(word[b*8 +: 8]);
        csum = csum ^ word[b*8 +: 8];
      end
      exp_q.push_back({5'(i), word});
    end
    tx_q.push_back(csum);
    do_start();
    check("full_drop", 64'({done, core_en}), 64'(2'b00));
    send_stream(1'b0, -1);
    check("full_cycles", 64'(cyc - t0), 64'(1 + 5 * DEPTH + 1));
    check("full_status", 64'({done, core_en, err, busy}), 64'(4'b1100));
    check_writes("full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
